// File: rtl/bd8_pwrsw_conditioner.sv
// Input conditioner for the power-mux / PCB status pins and the DIP-switch settings word.
// Optional macro BD8_GLITCH_COUNT_EN adds the GLITCH_CNT output (rejected-glitch counter).
module bd8_pwrsw_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int CNTR_WIDTH      = 20
) (
    input  logic       MCLK,
    input  logic       RST,
    input  logic       PWRSTAT_RAW,
    input  logic       MRST_RAW,
    input  logic [3:0] SETTINGSW,
    input  logic [1:0] DELAYSW,
    input  logic [3:0] IMGSELSW,
    input  logic       LATCH,
    output logic       PWRSTAT_S,
    output logic       MRST_S,
    output logic       STAT_VALID,
    output logic       STAT_CHG,
    output logic [9:0] SETTINGS,
    output logic       SETTINGS_VALID
`ifdef BD8_GLITCH_COUNT_EN
    ,
    output logic [7:0] GLITCH_CNT
`endif
);

    localparam logic [CNTR_WIDTH-1:0] CNT_ZERO = {CNTR_WIDTH{1'b0}};
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE  = CNTR_WIDTH'(1);
    localparam logic [CNTR_WIDTH-1:0] CNT_MAX  = {CNTR_WIDTH{1'b1}};
    localparam logic [CNTR_WIDTH-1:0] CNT_LAST = CNTR_WIDTH'(DEBOUNCE_CYCLES - 1);
    // Bit 0 = PWRSTAT, bit 1 = MRST; MRST resets high so downstream sees "board fault".
    localparam logic [1:0]            OUT_RST  = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_STABLE  = 2'd1,
        ST_PENDING = 2'd2
    } dbnc_state_e;

    logic [11:0]           sync_q [SYNC_STAGES];
    logic [11:0]           sync_d [SYNC_STAGES];
    logic [11:0]           s_bits;
    logic [1:0]            s;
    dbnc_state_e           state_q [2];
    dbnc_state_e           state_d [2];
    logic [CNTR_WIDTH-1:0] cnt_q [2];
    logic [CNTR_WIDTH-1:0] cnt_d [2];
    logic [1:0]            prev_q, prev_d;
    logic [1:0]            out_q, out_d;
    logic [1:0]            flip;
    logic                  stat_valid_q, stat_valid_d;
    logic                  stat_chg_q, stat_chg_d;
    logic [9:0]            settings_q, settings_d;
    logic                  settings_valid_q, settings_valid_d;

    // Synchronizer chain: {IMGSELSW, DELAYSW, SETTINGSW, MRST, PWRSTAT}
    always_comb begin
        sync_d[0] = {IMGSELSW, DELAYSW, SETTINGSW, MRST_RAW, PWRSTAT_RAW};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign s_bits = sync_q[SYNC_STAGES-1];
    assign s      = s_bits[1:0];

    // State register for synchronizers, debouncers, status and settings
    always_ff @(posedge MCLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 12'h000;
            end
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_INIT;
                cnt_q[i]   <= CNT_ZERO;
            end
            prev_q           <= 2'b00;
            out_q            <= OUT_RST;
            stat_valid_q     <= 1'b0;
            stat_chg_q       <= 1'b0;
            settings_q       <= 10'h000;
            settings_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prev_q           <= prev_d;
            out_q            <= out_d;
            stat_valid_q     <= stat_valid_d;
            stat_chg_q       <= stat_chg_d;
            settings_q       <= settings_d;
            settings_valid_q <= settings_valid_d;
        end
    end

    // Debouncer next-state logic, one FSM per status input
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_INIT: begin
                    if ((s[i] == prev_q[i]) && (cnt_q[i] == CNT_LAST)) state_d[i] = ST_STABLE;
                    else                                               state_d[i] = ST_INIT;
                end
                ST_STABLE: begin
                    if (s[i] != out_q[i]) state_d[i] = ST_PENDING;
                    else                  state_d[i] = ST_STABLE;
                end
                ST_PENDING: begin
                    if (s[i] == out_q[i])        state_d[i] = ST_STABLE;
                    else if (cnt_q[i] == CNT_LAST) state_d[i] = ST_STABLE;
                    else                         state_d[i] = ST_PENDING;
                end
                default: state_d[i] = ST_INIT;
            endcase
        end
    end

    // Debouncer counters and accepted levels
    always_comb begin
        prev_d = s;
        out_d  = out_q;
        flip   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            case (state_q[i])
                ST_INIT: begin
                    if (s[i] != prev_q[i]) begin
                        cnt_d[i] = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        cnt_d[i] = CNT_ZERO;
                        out_d[i] = s[i];
                    end else begin
                        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (s[i] == out_q[i]) cnt_d[i] = CNT_ZERO;
                    else                  cnt_d[i] = CNT_ONE;
                end
                ST_PENDING: begin
                    if (s[i] == out_q[i]) begin
                        cnt_d[i] = CNT_ZERO;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        cnt_d[i] = CNT_ZERO;
                        out_d[i] = s[i];
                        flip[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_ONE;
                    end
                end
                default: cnt_d[i] = CNT_ZERO;
            endcase
        end
    end

    // Status flags and DIP snapshot; the initial INIT->STABLE adoption never pulses STAT_CHG
    always_comb begin
        stat_valid_d = stat_valid_q | ((state_q[0] != ST_INIT) && (state_q[1] != ST_INIT));
        stat_chg_d   = stat_valid_q & (|flip);
        if (LATCH) begin
            settings_d       = {~s_bits[5:2], ~s_bits[7:6], ~s_bits[11:8]};
            settings_valid_d = 1'b1;
        end else begin
            settings_d       = settings_q;
            settings_valid_d = settings_valid_q;
        end
    end

`ifdef BD8_GLITCH_COUNT_EN
    logic [1:0] revert;
    logic [8:0] glitch_sum;
    logic [7:0] glitch_q, glitch_d;

    // Count PENDING->STABLE reverts, saturating at 8'hFF
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            revert[i] = (state_q[i] == ST_PENDING) && (s[i] == out_q[i]);
        end
        glitch_sum = {1'b0, glitch_q} + {8'h00, revert[0]} + {8'h00, revert[1]};
        if (glitch_sum > 9'h0FF) glitch_d = 8'hFF;
        else                     glitch_d = glitch_sum[7:0];
    end

    // Glitch counter register
    always_ff @(posedge MCLK) begin
        if (RST) glitch_q <= 8'h00;
        else     glitch_q <= glitch_d;
    end

    assign GLITCH_CNT = glitch_q;
`endif

    assign PWRSTAT_S      = out_q[0];
    assign MRST_S         = out_q[1];
    assign STAT_VALID     = stat_valid_q;
    assign STAT_CHG       = stat_chg_q;
    assign SETTINGS       = settings_q;
    assign SETTINGS_VALID = settings_valid_q;

endmodule
